// File: rtl/debounce3_pkg.sv
// rtl/debounce3_pkg.sv - shared board constants for the three-channel debouncer
// Purpose: IceZUM clock and debounce-time constants, plus the derived default
//          debounce length in clock cycles.
`timescale 1ns/1ps
package debounce3_pkg;

  localparam int CLK_HZ        = 12_000_000;
  localparam int DB_MS_DEFAULT = 20;

  // 20 ms at 12 MHz = 240000 clocks
  localparam int DB_CYCLES_DEFAULT = (CLK_HZ / 1000) * DB_MS_DEFAULT;

endpackage

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - one debounced push-button channel
// Purpose: two-flop synchroniser, stability counter, stable level register and
//          registered press pulse for a single raw switch input.
// Ports:
//   clk  - system clock
//   rstn - asynchronous active-low reset
//   sw   - raw active-high switch input, asynchronous to clk
//   x    - debounced stable level
//   p    - one-cycle pulse on each accepted 0->1 change of x
`timescale 1ns/1ps
module debounce_ch #(
  parameter int DB_CYCLES = 240000
) (
  input  logic clk,
  input  logic rstn,
  input  logic sw,
  output logic x,
  output logic p
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          st;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      st  <= 1'b0;
      cnt <= '0;
      p   <= 1'b0;
    end else begin
      s1 <= sw;
      s2 <= s1;
      p  <= 1'b0;
      if (s2 != st) begin
        if (cnt == CNT_LAST) begin
          // Accept the new level; pulse only when it is a rising update,
          // so p lines up with the first cycle x reads 1.
          st  <= s2;
          cnt <= '0;
          p   <= s2;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        // Any return to the stable level restarts the acceptance window.
        cnt <= '0;
      end
    end
  end

  assign x = st;

endmodule

// File: rtl/debounce3.sv
// rtl/debounce3.sv - three independent debounced push-button channels
// Purpose: wraps three identical debounce_ch instances for the IceZUM buttons.
// Ports:
//   clk           - 12 MHz system clock
//   rstn          - asynchronous active-low reset
//   sw0, sw1, sw2 - raw active-high button inputs
//   x0, x1, x2    - debounced stable levels
//   p0, p1, p2    - one-cycle press pulses
`timescale 1ns/1ps
module debounce3
  import debounce3_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rstn,
  input  logic sw0,
  input  logic sw1,
  input  logic sw2,
  output logic x0,
  output logic x1,
  output logic x2,
  output logic p0,
  output logic p1,
  output logic p2
);

  debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_ch0 (
    .clk  (clk),
    .rstn (rstn),
    .sw   (sw0),
    .x    (x0),
    .p    (p0)
  );

  debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_ch1 (
    .clk  (clk),
    .rstn (rstn),
    .sw   (sw1),
    .x    (x1),
    .p    (p1)
  );

  debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_ch2 (
    .clk  (clk),
    .rstn (rstn),
    .sw   (sw2),
    .x    (x2),
    .p    (p2)
  );

endmodule
